// File: rtl/ccff_prog_pkg.sv
// Shared types and width helpers for the configuration-chain programmer.
package ccff_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } ccff_prog_state_t;

    // Width of a counter that must reach n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into a w-bit word; a 1-bit word still needs one index bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ccff_bit_serializer.sv
// Holds the current host word and drives the chain data/clock pins, MSB first,
// with one low and one high prog_clk phase per bit.
module ccff_bit_serializer
    import ccff_prog_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_load,
    input  logic [DATA_W-1:0] din,
    input  logic              idx_dec,
    input  logic              enter_lo,
    input  logic              enter_hi,
    output logic              idx_zero,
    output logic              ccff_head,
    output logic              prog_clk
);

    localparam int IDX_W = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              head_q, head_d;
    logic              pclk_q, pclk_d;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        head_d = head_q;
        pclk_d = enter_hi;
        if (word_load) begin
            word_d = din;
            idx_d  = IDX_TOP;
        end else if (idx_dec) begin
            idx_d = idx_q - IDX_W'(1);
        end
        // Head moves only on entry to the low phase, a full cycle ahead of the rise.
        if (enter_lo) begin
            head_d = word_d[idx_d];
        end
    end

    // NOTE: the word register is data storage written before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            head_q <= 1'b0;
            pclk_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            head_q <= head_d;
            pclk_q <= pclk_d;
        end
    end

    assign idx_zero  = (idx_q == '0);
    assign ccff_head = head_q;
    assign prog_clk  = pclk_q;

endmodule

// File: rtl/ccff_chain_programmer.sv
// Host-to-config-chain writer: FSM, bit counter, valid/ready handshake and the
// optional tail-versus-head verify compare.
module ccff_chain_programmer
    import ccff_prog_pkg::*;
#(
    parameter int CHAIN_LEN = 28,
    parameter int DATA_W    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            verify,
    input  logic [DATA_W-1:0]               din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic                            prog_clk,
    output logic                            ccff_head,
    input  logic                            ccff_tail,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [cnt_width(CHAIN_LEN)-1:0] mismatch_cnt
);

    localparam int CNT_W = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);

    ccff_prog_state_t state_q, state_d;
    logic             verify_q, verify_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic             error_q, error_d;
    logic             din_ready_q, din_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             word_load, idx_dec, idx_zero;

    always_comb begin
        state_d   = state_q;
        verify_d  = verify_q;
        bit_cnt_d = bit_cnt_q;
        mism_d    = mism_q;
        error_d   = error_q;
        word_load = 1'b0;
        idx_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    verify_d  = verify;
                    bit_cnt_d = '0;
                    mism_d    = '0;
                    error_d   = 1'b0;
                end
            end
            LOAD: begin
                if (din_valid) begin
                    word_load = 1'b1;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                state_d = SHIFT_HI;
                // Tail still shows the old chain bit; a repeated pass must match it.
                if (verify_q && (ccff_tail != ccff_head)) begin
                    error_d = 1'b1;
                    if (mism_q != CNT_MAX) begin
                        mism_d = mism_q + CNT_W'(1);
                    end
                end
            end
            SHIFT_HI: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else if (idx_zero) begin
                    state_d = LOAD;
                end else begin
                    idx_dec = 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        din_ready_d = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            verify_q    <= 1'b0;
            bit_cnt_q   <= '0;
            mism_q      <= '0;
            error_q     <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            verify_q    <= verify_d;
            bit_cnt_q   <= bit_cnt_d;
            mism_q      <= mism_d;
            error_q     <= error_d;
            din_ready_q <= din_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    ccff_bit_serializer #(
        .DATA_W(DATA_W)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .word_load(word_load),
        .din      (din),
        .idx_dec  (idx_dec),
        .enter_lo (state_d == SHIFT_LO),
        .enter_hi (state_d == SHIFT_HI),
        .idx_zero (idx_zero),
        .ccff_head(ccff_head),
        .prog_clk (prog_clk)
    );

    assign din_ready    = din_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign mismatch_cnt = mism_q;

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Directed bench for ccff_chain_programmer driving a 28-bit behavioural chain.
module tb_ccff_chain_programmer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        verify = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        din_ready, prog_clk, ccff_head, ccff_tail;
    logic        busy, done, error;
    logic [4:0]  mismatch_cnt;
    logic [27:0] chain = 28'h0;

    int checks = 0;
    int failures = 0;

    int         done_cycle, pulses, hs, stall_bad, idle_bad;
    logic       err_at_done, busy_after;
    logic [4:0] mc_at_done;

    always #5 clk = ~clk;

    // Chain model: index 0 at the head, index 27 drives ccff_tail.
    always @(posedge prog_clk) chain <= {chain[26:0], ccff_head};
    assign ccff_tail = chain[27];

    ccff_chain_programmer #(
        .CHAIN_LEN(28),
        .DATA_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .verify      (verify),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .prog_clk    (prog_clk),
        .ccff_head   (ccff_head),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .mismatch_cnt(mismatch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One pass: words packed MSB-first, optional stall before word stall_word,
    // optional stray start at cycle poke, optional reset at cycle rst_cycle.
    task automatic run_pass(input logic [31:0] words, input logic vfy, input int stall_word,
                            input int stall_len, input int poke, input int rst_cycle);
        int n = 0;
        int wi = 0;
        int stall_left = stall_len;
        bit stop = 0;
        done_cycle = 0; pulses = 0; hs = 0; stall_bad = 0;
        err_at_done = 1'bx; mc_at_done = 'x; busy_after = 1'bx;
        while (!stop && n < 400) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                pulses++;
                if (done_cycle == 0) begin
                    done_cycle  = n;
                    err_at_done = error;
                    mc_at_done  = mismatch_cnt;
                end
            end
            if (done_cycle != 0 && n == done_cycle + 1) busy_after = busy;
            if (n == rst_cycle) begin
                reset = 1'b0;
                #1;
                check("rst_mid_outputs",
                      32'({prog_clk, ccff_head, din_ready, busy, done, error, mismatch_cnt}), 32'h0);
                @(negedge clk);
                reset = 1'b1;
                stop = 1;
            end else begin
                start = (n == 1) || (n == poke);
                if (n == 1) verify = vfy;
                if (din_ready && wi == stall_word && stall_left > 0) begin
                    stall_left--;
                    din_valid = 1'b0;
                    if (prog_clk !== 1'b0 || ccff_head !== words[32-8*wi]) stall_bad++;
                end else if (din_ready && wi < 4) begin
                    din_valid = 1'b1;
                    din = words[31-8*wi -: 8];
                    hs++;
                    wi++;
                end else begin
                    din_valid = 1'b0;
                end
                if (done_cycle != 0 && n >= done_cycle + 3) stop = 1;
            end
        end
        start = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({prog_clk, ccff_head, din_ready, busy, done, error, mismatch_cnt}), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Plain write of A5 3C F0 9x.
        run_pass(32'hA53CF096, 1'b0, -1, 0, 0, 0);
        check("a_done_cycle", 32'(done_cycle), 32'd62);
        check("a_done_pulses", 32'(pulses), 32'd1);
        check("a_handshakes", 32'(hs), 32'd4);
        check("a_chain", 32'(chain), 32'h0A53CF09);
        check("a_busy_after_done", 32'(busy_after), 32'd0);

        // Identical stream with verify.
        run_pass(32'hA53CF096, 1'b1, -1, 0, 0, 0);
        check("b_error", 32'(err_at_done), 32'd0);
        check("b_mismatch", 32'(mc_at_done), 32'd0);
        check("b_chain", 32'(chain), 32'h0A53CF09);

        // One bit of word 1 flipped.
        run_pass(32'hA52CF096, 1'b1, -1, 0, 0, 0);
        check("c_error", 32'(err_at_done), 32'd1);
        check("c_mismatch", 32'(mc_at_done), 32'd1);
        check("c_chain", 32'(chain), 32'h0A52CF09);

        // All 28 bits flipped against the chain contents.
        run_pass(32'h5AD30F60, 1'b1, -1, 0, 0, 0);
        check("d_error", 32'(err_at_done), 32'd1);
        check("d_mismatch", 32'(mc_at_done), 32'd28);
        check("d_chain", 32'(chain), 32'h05AD30F6);

        // Five-cycle host stall before word 1; error/count cleared by start.
        run_pass(32'hA53CF096, 1'b0, 1, 5, 0, 0);
        check("e_done_cycle", 32'(done_cycle), 32'd67);
        check("e_stall_hold", 32'(stall_bad), 32'd0);
        check("e_error_cleared", 32'(err_at_done), 32'd0);
        check("e_mismatch_cleared", 32'(mc_at_done), 32'd0);
        check("e_chain", 32'(chain), 32'h0A53CF09);

        // Stray start during SHIFT_HI (cycle 10).
        run_pass(32'h3CA59600, 1'b0, -1, 0, 10, 0);
        check("f_done_cycle", 32'(done_cycle), 32'd62);
        check("f_done_pulses", 32'(pulses), 32'd1);
        check("f_handshakes", 32'(hs), 32'd4);
        check("f_chain", 32'(chain), 32'h03CA5960);

        // Valid offered while idle must not be taken.
        idle_bad = 0;
        @(negedge clk);
        din_valid = 1'b1;
        din = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (din_ready !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        din_valid = 1'b0;
        check("g_idle_ready_low", 32'(idle_bad), 32'd0);
        run_pass(32'hA53CF096, 1'b0, -1, 0, 0, 0);
        check("g_handshakes", 32'(hs), 32'd4);
        check("g_chain", 32'(chain), 32'h0A53CF09);

        // Reset during bit 13 of a mismatching verify pass, then a full rewrite.
        run_pass(32'h5AD30F60, 1'b1, -1, 0, 0, 30);
        run_pass(32'hDEADBEE0, 1'b0, -1, 0, 0, 0);
        check("i_done_cycle", 32'(done_cycle), 32'd62);
        check("i_chain", 32'(chain), 32'h0DEADBEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
